// File: rtl/dld_seg_pkg.sv
// Shared seven-segment constants, message character codes and scroller FSM states.
// Segment vectors are indexed [0:6] = a..g, active-low.
package dld_seg_pkg;

   localparam logic [0:6] SEG_0     = 7'b0000001;
   localparam logic [0:6] SEG_1     = 7'b1001111;
   localparam logic [0:6] SEG_E     = 7'b0110000;
   localparam logic [0:6] SEG_d     = 7'b1000010;
   localparam logic [0:6] SEG_BLANK = 7'b1111111;

   localparam int MSG_LEN = 8;

   typedef enum logic [2:0] {
      CH_D     = 3'd0,
      CH_E     = 3'd1,
      CH_1     = 3'd2,
      CH_0     = 3'd3,
      CH_BLANK = 3'd4
   } char_t;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   // Fixed message "dE10" followed by four blanks.
   function automatic char_t msg_char(input logic [2:0] idx);
      case (idx)
         3'd0:    return CH_D;
         3'd1:    return CH_E;
         3'd2:    return CH_1;
         3'd3:    return CH_0;
         default: return CH_BLANK;
      endcase
   endfunction

   function automatic logic [0:6] char_seg(input char_t ch);
      case (ch)
         CH_D:    return SEG_d;
         CH_E:    return SEG_E;
         CH_1:    return SEG_1;
         CH_0:    return SEG_0;
         default: return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/key_pulse.sv
// Two-flop synchroniser plus falling-edge detector for one active-low pushbutton.
// A press produces a single one-cycle pulse no matter how long it is held.
module key_pulse (
   input  logic CLOCK_50,
   input  logic rst_n,
   input  logic key,
   output logic pulse
);

   logic sync1;
   logic sync2;
   logic sync2_d;

   // Synchronisers reset to the released level so reset itself never looks like a press.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         sync1   <= 1'b1;
         sync2   <= 1'b1;
         sync2_d <= 1'b1;
      end else begin
         sync1   <= key;
         sync2   <= sync1;
         sync2_d <= sync2;
      end
   end

   assign pulse = sync2_d & ~sync2;

endmodule

// File: rtl/hex_scroll_controller.sv
// Scrolls the 8-character message across HEX3..HEX0 with pause, direction and
// four speed levels driven from KEY[3:1]; KEY[0] is the async active-low reset.
module hex_scroll_controller
   import dld_seg_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic       CLOCK_50,
   input  logic [3:0] KEY,
   output logic [0:6] HEX3,
   output logic [0:6] HEX2,
   output logic [0:6] HEX1,
   output logic [0:6] HEX0
);

   localparam int CW = $clog2(TICK_DIV);

   logic          rst_n;
   logic          pause_p;
   logic          dir_p;
   logic          speed_p;
   logic [CW-1:0] presc;
   logic [1:0]    speed;
   logic [31:0]   period;
   logic          tick;
   state_t        state;
   state_t        state_next;
   logic [2:0]    pos;
   logic [2:0]    pos_next;
   logic          dir;
   logic          dir_next;
   logic          blink;
   logic          blink_next;
   logic          blank_all;

   assign rst_n = KEY[0];

   key_pulse u_pause (.CLOCK_50(CLOCK_50), .rst_n(rst_n), .key(KEY[1]), .pulse(pause_p));
   key_pulse u_dir   (.CLOCK_50(CLOCK_50), .rst_n(rst_n), .key(KEY[2]), .pulse(dir_p));
   key_pulse u_speed (.CLOCK_50(CLOCK_50), .rst_n(rst_n), .key(KEY[3]), .pulse(speed_p));

   // A speed change restarts the prescaler and suppresses that cycle's tick.
   assign period = 32'(TICK_DIV) >> speed;
   assign tick   = (presc == CW'(period - 32'd1)) && !speed_p;

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
         speed <= 2'd0;
      end else if (speed_p) begin
         presc <= '0;
         speed <= speed + 2'd1;
      end else if (tick) begin
         presc <= '0;
      end else begin
         presc <= presc + CW'(1);
      end
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_INIT;
         pos   <= 3'd0;
         dir   <= 1'b0;
         blink <= 1'b0;
      end else begin
         state <= state_next;
         pos   <= pos_next;
         dir   <= dir_next;
         blink <= blink_next;
      end
   end

   // Pause beats a coincident tick; a step always uses the direction held before this cycle.
   always_comb begin
      state_next = state;
      pos_next   = pos;
      dir_next   = dir;
      blink_next = blink;
      unique case (state)
         ST_INIT: begin
            if (tick) state_next = ST_RUN;
         end
         ST_RUN: begin
            if (dir_p) dir_next = ~dir;
            if (pause_p) begin
               state_next = ST_PAUSE;
               blink_next = 1'b0;
            end else if (tick) begin
               pos_next = dir ? pos - 3'd1 : pos + 3'd1;
            end
         end
         ST_PAUSE: begin
            if (dir_p) dir_next = ~dir;
            if (pause_p) begin
               state_next = ST_RUN;
               blink_next = 1'b0;
            end else if (tick) begin
               blink_next = ~blink;
            end
         end
         default: state_next = ST_INIT;
      endcase
   end

   assign blank_all = (state == ST_INIT) || ((state == ST_PAUSE) && blink);

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         HEX3 <= SEG_BLANK;
         HEX2 <= SEG_BLANK;
         HEX1 <= SEG_BLANK;
         HEX0 <= SEG_BLANK;
      end else if (blank_all) begin
         HEX3 <= SEG_BLANK;
         HEX2 <= SEG_BLANK;
         HEX1 <= SEG_BLANK;
         HEX0 <= SEG_BLANK;
      end else begin
         HEX3 <= char_seg(msg_char(pos));
         HEX2 <= char_seg(msg_char(pos + 3'd1));
         HEX1 <= char_seg(msg_char(pos + 3'd2));
         HEX0 <= char_seg(msg_char(pos + 3'd3));
      end
   end

endmodule

// File: tb/tb_hex_scroll_controller.sv
// Scoreboarded bench for hex_scroll_controller with TICK_DIV=8: stimulus queues
// cycle-stamped display expectations, a negedge monitor checks every display change.
module tb_hex_scroll_controller;

   localparam logic [0:6] S_B = 7'b1111111;
   localparam logic [0:6] S_D = 7'b1000010;
   localparam logic [0:6] S_E = 7'b0110000;
   localparam logic [0:6] S_1 = 7'b1001111;
   localparam logic [0:6] S_0 = 7'b0000001;
   localparam logic [27:0] V_BLANK = {S_B, S_B, S_B, S_B};

   typedef struct {
      int          cyc;
      logic [27:0] val;
      string       tag;
   } exp_t;

   exp_t        exp_q[$];
   logic        CLOCK_50 = 1'b0;
   logic [3:0]  KEY = 4'hF;
   logic [0:6]  HEX3;
   logic [0:6]  HEX2;
   logic [0:6]  HEX1;
   logic [0:6]  HEX0;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   bit          mon_en = 1'b0;
   logic [27:0] prev = V_BLANK;

   hex_scroll_controller #(.TICK_DIV(8)) dut (
      .CLOCK_50(CLOCK_50),
      .KEY(KEY),
      .HEX3(HEX3),
      .HEX2(HEX2),
      .HEX1(HEX1),
      .HEX0(HEX0)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) cyc <= cyc + 1;

   // Hand-written view of HEX3..HEX0 for each scroll position of "dE10____".
   function automatic logic [27:0] view(input int p);
      case (p)
         0:       return {S_D, S_E, S_1, S_0};
         1:       return {S_E, S_1, S_0, S_B};
         2:       return {S_1, S_0, S_B, S_B};
         3:       return {S_0, S_B, S_B, S_B};
         4:       return {S_B, S_B, S_B, S_B};
         5:       return {S_B, S_B, S_B, S_D};
         6:       return {S_B, S_B, S_D, S_E};
         default: return {S_B, S_D, S_E, S_1};
      endcase
   endfunction

   task automatic expect_at(input int c, input logic [27:0] v, input string tag);
      exp_t e;
      e.cyc = c;
      e.val = v;
      e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic advance_to(input int c);
      while (cyc < c) begin
         @(posedge CLOCK_50);
         #2;
      end
   endtask

   // Monitor: checks scheduled entries and flags any display change nobody predicted.
   always @(negedge CLOCK_50) begin
      if (mon_en) begin
         logic [27:0] cur;
         cur = {HEX3, HEX2, HEX1, HEX0};
         while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            total++;
            bad++;
            $display("[TB] FAIL %s missed cyc=%0d want=%b", exp_q[0].tag, exp_q[0].cyc, exp_q[0].val);
            void'(exp_q.pop_front());
         end
         if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
            total++;
            if (cur !== exp_q[0].val) begin
               bad++;
               $display("[TB] FAIL %s cyc=%0d got=%b want=%b", exp_q[0].tag, cyc, cur, exp_q[0].val);
            end
            void'(exp_q.pop_front());
         end else if (cur !== prev) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_change cyc=%0d got=%b want=%b", cyc, cur, prev);
         end
         prev = cur;
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog cyc=%0d got=running want=finished", cyc);
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset held three cycles, then INIT for eight cycles before the first view.
      advance_to(1);
      KEY[0] = 1'b0;
      mon_en = 1'b1;
      for (int c = 1; c <= 4; c++) expect_at(c, V_BLANK, "reset_blank");
      advance_to(4);
      KEY[0] = 1'b1;
      expect_at(12, V_BLANK, "init_latency");
      expect_at(13, view(0), "first_view");

      // Forward scroll through a full wrap.
      for (int p = 1; p <= 8; p++) expect_at(13 + 8 * p, view(p % 8), "fwd_step");

      // Direction toggle at pos 0 wraps to 7.
      advance_to(77);
      KEY[2] = 1'b0;
      expect_at(85, view(7), "rev_wrap");
      expect_at(93, view(6), "rev_step");
      advance_to(79);
      KEY[2] = 1'b1;

      // Pause coincident with a tick: no step, then blink every 8 cycles.
      advance_to(97);
      KEY[1] = 1'b0;
      expect_at(101, view(6), "pause_no_step");
      expect_at(109, V_BLANK, "blink_off");
      expect_at(117, view(6), "blink_on");
      expect_at(125, V_BLANK, "blink_off");
      advance_to(99);
      KEY[1] = 1'b1;
      advance_to(127);
      KEY[1] = 1'b0;
      expect_at(131, view(6), "resume_visible");
      expect_at(133, view(5), "resume_step");
      expect_at(141, view(4), "resume_step");
      advance_to(129);
      KEY[1] = 1'b1;

      // Held speed key: one increment, prescaler restart, period 4.
      advance_to(142);
      KEY[3] = 1'b0;
      expect_at(149, view(4), "speed_restart");
      expect_at(150, view(3), "speed1_step");
      expect_at(154, view(2), "speed1_step");
      expect_at(158, view(1), "speed1_step");
      expect_at(162, view(0), "speed1_step");
      expect_at(166, view(7), "speed1_step");
      advance_to(162);
      KEY[3] = 1'b1;

      // Speed pulses landing on ticks suppress the step; speeds 2, 3, then back to 0.
      advance_to(166);
      KEY[3] = 1'b0;
      expect_at(170, view(7), "speed_wins");
      expect_at(172, view(6), "speed2_step");
      advance_to(168);
      KEY[3] = 1'b1;
      advance_to(170);
      KEY[3] = 1'b0;
      expect_at(174, view(6), "speed_wins");
      expect_at(175, view(5), "speed3_step");
      expect_at(176, view(4), "speed3_step");
      expect_at(177, view(3), "speed3_step");
      advance_to(172);
      KEY[3] = 1'b1;
      advance_to(174);
      KEY[3] = 1'b0;
      expect_at(185, view(3), "speed0_hold");
      expect_at(186, view(2), "speed0_step");
      expect_at(194, view(1), "speed0_step");
      advance_to(176);
      KEY[3] = 1'b1;

      // Pause, speed up while paused, then a one-cycle reset mid-blink.
      advance_to(195);
      KEY[1] = 1'b0;
      expect_at(199, view(1), "pause2_visible");
      expect_at(202, V_BLANK, "pause2_blink");
      expect_at(207, view(1), "pause2_fast_blink");
      advance_to(197);
      KEY[1] = 1'b1;
      advance_to(199);
      KEY[3] = 1'b0;
      advance_to(201);
      KEY[3] = 1'b1;
      advance_to(208);
      KEY[0] = 1'b0;
      expect_at(208, V_BLANK, "async_reset");
      advance_to(209);
      KEY[0] = 1'b1;
      expect_at(217, V_BLANK, "init2_latency");
      expect_at(218, view(0), "init2_view");
      expect_at(226, view(1), "init2_fwd");
      expect_at(234, view(2), "init2_fwd");

      // Pause press during INIT must be ignored.
      advance_to(211);
      KEY[1] = 1'b0;
      advance_to(213);
      KEY[1] = 1'b1;

      advance_to(240);
      mon_en = 1'b0;
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("[TB] FAIL leftover_expectations got=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
